// File: rtl/mem_dump_streamer.sv
// rtl/mem_dump_streamer.sv - end-of-run data-memory dump streamer
//
// Purpose:
//   Watches the MEM/WB finish flag. On its rising edge it freezes a free-running
//   cycle counter, walks data memory 0..DEPTH-1 through a synchronous read port
//   and streams every word on a valid/ready interface. It is single-shot: once
//   the dump completes it stays in DONE until reset.
//
// Optional feature:
//   MEM_DUMP_HEADER_EN - when defined, a header beat carrying the frozen cycle
//   count (dump_hdr_o=1) precedes the memory beats.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   finish_i         finish level from MEM/WB; its rising edge starts the dump
//   mem_rd_en_o      memory read enable (data returns on the next cycle)
//   mem_addr_o       memory read address
//   mem_rd_data_i    memory read data
//   dump_valid_o     beat valid
//   dump_ready_i     sink ready
//   dump_data_o      beat payload
//   dump_addr_o      memory address of the beat
//   dump_last_o      beat is address DEPTH-1
//   dump_hdr_o       beat is the cycle-count header
//   busy_o           dump in progress
//   done_o           dump finished (sticky until reset)
//   cycle_count_o    cycles counted before the finish edge

module mem_dump_streamer #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              finish_i,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [DATA_W-1:0] dump_data_o,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic              dump_last_o,
   output logic              dump_hdr_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [31:0]       cycle_count_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_SEND = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
`ifdef MEM_DUMP_HEADER_EN
   localparam logic [2:0] S_HDR  = 3'd5;
`endif

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              finish_q;
   logic [31:0]       cycle_q, cycle_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] daddr_q, daddr_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
`ifdef MEM_DUMP_HEADER_EN
   logic              hdr_q, hdr_d;
`endif

   logic trig;
   logic xfer;
   logic at_last_addr;

   assign trig         = finish_i & ~finish_q;
   assign xfer         = valid_q & dump_ready_i;
   assign at_last_addr = (addr_q == ADDR_W'(DEPTH - 1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cycle_d = cycle_q;
      data_d  = data_q;
      daddr_d = daddr_q;
      valid_d = valid_q;
      last_d  = last_q;
`ifdef MEM_DUMP_HEADER_EN
      hdr_d   = hdr_q;
`endif

      // Counter runs only while waiting; the trigger edge itself is not counted,
      // so the value seen after the trigger equals the number of idle edges.
      if (state_q == S_IDLE && !trig && cycle_q != 32'hFFFF_FFFF) begin
         cycle_d = cycle_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (trig) begin
`ifdef MEM_DUMP_HEADER_EN
               state_d = S_HDR;
               valid_d = 1'b1;
               data_d  = DATA_W'(cycle_q);
               daddr_d = '0;
               last_d  = 1'b0;
               hdr_d   = 1'b1;
`else
               state_d = S_READ;
`endif
            end
         end
         S_READ: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            // Read data is valid this cycle; register it as the outgoing beat.
            data_d  = mem_rd_data_i;
            daddr_d = addr_q;
            valid_d = 1'b1;
            last_d  = at_last_addr;
`ifdef MEM_DUMP_HEADER_EN
            hdr_d   = 1'b0;
`endif
            state_d = S_SEND;
         end
         S_SEND: begin
            if (xfer) begin
               valid_d = 1'b0;
               if (last_q) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = S_READ;
               end
            end
         end
`ifdef MEM_DUMP_HEADER_EN
         S_HDR: begin
            if (xfer) begin
               valid_d = 1'b0;
               hdr_d   = 1'b0;
               state_d = S_READ;
            end
         end
`endif
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         finish_q <= 1'b0;
         cycle_q  <= '0;
         data_q   <= '0;
         daddr_q  <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
`ifdef MEM_DUMP_HEADER_EN
         hdr_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         finish_q <= finish_i;
         cycle_q  <= cycle_d;
         data_q   <= data_d;
         daddr_q  <= daddr_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
`ifdef MEM_DUMP_HEADER_EN
         hdr_q    <= hdr_d;
`endif
      end
   end

   assign mem_rd_en_o   = (state_q == S_READ);
   assign mem_addr_o    = addr_q;
   assign dump_valid_o  = valid_q;
   assign dump_data_o   = data_q;
   assign dump_addr_o   = daddr_q;
   assign dump_last_o   = last_q;
`ifdef MEM_DUMP_HEADER_EN
   assign dump_hdr_o    = hdr_q;
`else
   assign dump_hdr_o    = 1'b0;
`endif
   assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o        = (state_q == S_DONE);
   assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// tb/tb_mem_dump_streamer.sv - self-checking bench for mem_dump_streamer

module tb_mem_dump_streamer;

   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
`ifdef MEM_DUMP_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int BUDGET = 3 * DEPTH + 200;

   logic              clk;
   logic              reset;
   logic              finish_i;
   logic              mem_rd_en_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_rd_data_i;
   logic              dump_valid_o;
   logic              dump_ready_i;
   logic [DATA_W-1:0] dump_data_o;
   logic [ADDR_W-1:0] dump_addr_o;
   logic              dump_last_o;
   logic              dump_hdr_o;
   logic              busy_o;
   logic              done_o;
   logic [31:0]       cycle_count_o;

   mem_dump_streamer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .finish_i      (finish_i),
      .mem_rd_en_o   (mem_rd_en_o),
      .mem_addr_o    (mem_addr_o),
      .mem_rd_data_i (mem_rd_data_i),
      .dump_valid_o  (dump_valid_o),
      .dump_ready_i  (dump_ready_i),
      .dump_data_o   (dump_data_o),
      .dump_addr_o   (dump_addr_o),
      .dump_last_o   (dump_last_o),
      .dump_hdr_o    (dump_hdr_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .cycle_count_o (cycle_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory model, word[i] = 4*i + 1.
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_rd_en_o) mem_rd_data_i <= mem[mem_addr_o];
   end

   typedef struct {
      int trig_cycle;
      int stall_beat;
      int stall_len;
      bit toggle;
      int abort_beat;
      int exp_count;
      int exp_cycles;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              last;
      logic              hdr;
   } beat_t;

   vec_t  vecs [6];
   beat_t sb [$];

   int checks;
   int errors;
   int beats_seen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Output monitor: a beat transfers on the next posedge when valid&ready at negedge.
   logic              pv, pr, pl;
   logic [DATA_W-1:0] pd;
   logic [ADDR_W-1:0] pa;
   always @(negedge clk) begin
      beat_t e;
      if (reset) begin
         pv = 1'b0;
         pr = 1'b1;
      end else begin
         if (pv && !pr) begin
            check("stall_hold", {dump_valid_o, dump_data_o, dump_addr_o, dump_last_o},
                  {1'b1, pd, pa, pl});
         end
         if (dump_valid_o && dump_ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat actual addr=%0d data=%0h expected no beat",
                        dump_addr_o, dump_data_o);
            end else begin
               e = sb.pop_front();
               check("beat", {dump_addr_o, dump_data_o, dump_last_o, dump_hdr_o},
                     {e.addr, e.data, e.last, e.hdr});
               beats_seen++;
            end
         end
         pv = dump_valid_o;
         pr = dump_ready_i;
         pd = dump_data_o;
         pa = dump_addr_o;
         pl = dump_last_o;
      end
   end

   task automatic run_vec(input vec_t t);
      int  cycles;
      bit  aborted;
      bit  stall_started;
      int  stall_cnt;
      beat_t b;

      @(posedge clk); #1;
      reset        = 1'b1;
      dump_ready_i = 1'b1;
      finish_i     = (t.trig_cycle == 0);
      sb.delete();
      beats_seen   = 0;
      #1;
      check("reset_ctrl", {mem_rd_en_o, mem_addr_o, dump_valid_o, dump_addr_o, dump_last_o,
                           dump_hdr_o, busy_o, done_o}, 64'd0);
      check("reset_data", {dump_data_o, cycle_count_o}, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < t.trig_cycle; i++) begin
         @(posedge clk); #1;
      end
      if (t.trig_cycle > 0) begin
         check("idle_count", {busy_o, cycle_count_o}, {1'b0, 32'(t.trig_cycle)});
      end
      finish_i = 1'b1;

      if (HDR != 0) begin
         b.addr = '0; b.data = DATA_W'(t.exp_count); b.last = 1'b0; b.hdr = 1'b1;
         sb.push_back(b);
      end
      for (int k = 0; k < DEPTH; k++) begin
         b.addr = ADDR_W'(k); b.data = DATA_W'(4 * k + 1); b.last = (k == DEPTH - 1); b.hdr = 1'b0;
         sb.push_back(b);
      end

      @(posedge clk); #1;
      check("busy_after_trig", busy_o, 1);
      check("cycle_count", cycle_count_o, 64'(t.exp_count));

      cycles        = 0;
      aborted       = 1'b0;
      stall_started = 1'b0;
      stall_cnt     = 0;
      while (!done_o && cycles < BUDGET && !aborted) begin
         if (t.abort_beat >= 0 && beats_seen >= t.abort_beat) begin
            reset = 1'b1;
            #1;
            check("abort_ctrl", {mem_rd_en_o, mem_addr_o, dump_valid_o, dump_addr_o,
                                 dump_last_o, busy_o, done_o}, 64'd0);
            check("abort_data", {dump_data_o, cycle_count_o}, 64'd0);
            aborted = 1'b1;
         end else begin
            @(posedge clk); #1;
            cycles++;
            if (t.stall_beat >= 0 && !stall_started && dump_valid_o && !dump_hdr_o &&
                dump_addr_o == ADDR_W'(t.stall_beat)) begin
               dump_ready_i  = 1'b0;
               stall_started = 1'b1;
            end else if (stall_started && !dump_ready_i) begin
               stall_cnt++;
               if (stall_cnt == t.stall_len) dump_ready_i = 1'b1;
            end
            if (t.toggle) begin
               if (cycles == 30) finish_i = 1'b0;
               if (cycles == 40) finish_i = 1'b1;
               if (cycles == 50) finish_i = 1'b0;
               if (cycles == 60) finish_i = 1'b1;
            end
         end
      end

      if (aborted) begin
         @(posedge clk); #1;
         check("abort_hold", {dump_valid_o, busy_o, done_o}, 64'd0);
      end else begin
         check("done_cycles", cycles, 64'(t.exp_cycles));
         check("busy_at_done", busy_o, 0);
         check("all_beats", sb.size(), 0);
         finish_i = 1'b0;
         @(posedge clk); #1;
         finish_i = 1'b1;
         repeat (5) begin
            @(posedge clk); #1;
         end
         check("done_sticky", {done_o, busy_o, dump_valid_o, cycle_count_o},
               {1'b1, 1'b0, 1'b0, 32'(t.exp_count)});
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      beats_seen   = 0;
      reset        = 1'b1;
      finish_i     = 1'b0;
      dump_ready_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(4 * i + 1);

      //          trig stall len tog abort count cycles
      vecs[0] = '{10, -1, 0, 1'b0, -1, 10, 3 * DEPTH + HDR};
      vecs[1] = '{ 5,  3, 7, 1'b0, -1,  5, 3 * DEPTH + 7 + HDR};
      vecs[2] = '{20, -1, 0, 1'b1, -1, 20, 3 * DEPTH + HDR};
      vecs[3] = '{ 7, -1, 0, 1'b0, 100, 7, 0};
      vecs[4] = '{25, -1, 0, 1'b0, -1, 25, 3 * DEPTH + HDR};
      vecs[5] = '{ 0, -1, 0, 1'b0, -1,  0, 3 * DEPTH + HDR};

      for (int v = 0; v < 6; v++) begin
         run_vec(vecs[v]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
